// File: rtl/icache_nb_if.sv
// Tagged memory bus between icache_nb (master) and the instruction memory (slave).
interface icache_nb_if #(
  parameter int unsigned NUM_MEM_TAGS = 16
);
  localparam int unsigned TW = $clog2(NUM_MEM_TAGS);

  logic [1:0]    proc2Imem_command;
  logic [63:0]   proc2Imem_addr;
  logic [TW-1:0] Imem2proc_response;
  logic [63:0]   Imem2proc_data;
  logic [TW-1:0] Imem2proc_tag;

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );
endinterface

// File: rtl/icache_nb.sv
// Non-blocking direct-mapped instruction cache with an MSHR file and fill bypass.
// Optional next-line prefetcher enabled by defining ICACHE_PREFETCH_EN.
module icache_nb #(
  parameter int unsigned NUM_LINES    = 32,
  parameter int unsigned MSHR_DEPTH   = 4,
  parameter int unsigned NUM_MEM_TAGS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [63:0]        proc2Icache_addr,
  input  logic               branch_taken,
  icache_nb_if.master        mem,
  output logic [63:0]        Icache_data_out,
  output logic               Icache_valid_out,
  output logic               mshr_full
);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 61 - IDX_W;
  localparam int unsigned TW    = $clog2(NUM_MEM_TAGS);

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_t;

  logic [NUM_LINES-1:0]  r_line_valid;
  logic [TAG_W-1:0]      r_line_tag  [NUM_LINES];
  logic [63:0]           r_line_data [NUM_LINES];

  logic [MSHR_DEPTH-1:0] r_mshr_valid;
  logic [60:0]           r_mshr_line [MSHR_DEPTH];
  logic [TW-1:0]         r_mshr_tag  [MSHR_DEPTH];

  logic [60:0]           w_fetch_line;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_bypass;
  logic                  w_fetch_in_mshr;
  logic                  w_full;
  logic                  w_demand;
  logic                  w_pf_issue;
  logic [60:0]           w_pf_line;
  logic                  w_issue;
  logic [60:0]           w_req_line;
  logic                  w_resp_ok;
  logic                  w_accept;
  logic [MSHR_DEPTH-1:0] w_fill_oh;
  logic [MSHR_DEPTH-1:0] w_alloc_oh;
  logic                  w_fill_any;
  logic [60:0]           w_fill_line;
  logic [IDX_W-1:0]      w_fill_idx;
  logic                  w_unused_addr_bits;

  assign w_fetch_line       = proc2Icache_addr[63:3];
  assign w_idx              = proc2Icache_addr[3 +: IDX_W];
  assign w_tag              = proc2Icache_addr[63:3+IDX_W];
  assign w_unused_addr_bits = ^proc2Icache_addr[2:0];

  assign w_hit     = r_line_valid[w_idx] && (r_line_tag[w_idx] == w_tag);
  assign w_full    = &r_mshr_valid;
  assign w_resp_ok = (mem.Imem2proc_response != '0);

  always_comb begin
    w_fill_oh       = '0;
    w_alloc_oh      = '0;
    w_bypass        = 1'b0;
    w_fetch_in_mshr = 1'b0;
    w_fill_any      = 1'b0;
    w_fill_line     = '0;
    for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
      w_fill_oh[i] = r_mshr_valid[i] && (mem.Imem2proc_tag != '0) &&
                     (r_mshr_tag[i] == mem.Imem2proc_tag);
      if (w_fill_oh[i] && (r_mshr_line[i] == w_fetch_line))
        w_bypass = 1'b1;
      if (r_mshr_valid[i] && (r_mshr_line[i] == w_fetch_line))
        w_fetch_in_mshr = 1'b1;
      if (w_fill_oh[i] && !w_fill_any) begin
        w_fill_any  = 1'b1;
        w_fill_line = r_mshr_line[i];
      end
      if (!r_mshr_valid[i] && (w_alloc_oh == '0))
        w_alloc_oh[i] = 1'b1;
    end
  end

  assign w_fill_idx = w_fill_line[IDX_W-1:0];

  assign w_demand = !w_hit && !w_bypass && !w_fetch_in_mshr && !w_full && !branch_taken;

`ifdef ICACHE_PREFETCH_EN
  logic        r_pf_pend;
  logic [60:0] r_pf_line;
  logic        w_pf_present;

  always_comb begin
    w_pf_present = r_line_valid[r_pf_line[IDX_W-1:0]] &&
                   (r_line_tag[r_pf_line[IDX_W-1:0]] == r_pf_line[60:IDX_W]);
    for (int unsigned i = 0; i < MSHR_DEPTH; i++)
      if (r_mshr_valid[i] && (r_mshr_line[i] == r_pf_line))
        w_pf_present = 1'b1;
  end

  assign w_pf_issue = r_pf_pend && !w_demand && !w_full && !w_pf_present && !branch_taken;
  assign w_pf_line  = r_pf_line;

  // A newly accepted demand miss retargets the prefetcher; a redirect always cancels it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pf_pend <= 1'b0;
      r_pf_line <= '0;
    end else if (branch_taken) begin
      r_pf_pend <= 1'b0;
    end else if (w_demand && w_resp_ok) begin
      r_pf_pend <= 1'b1;
      r_pf_line <= w_fetch_line + 61'd1;
    end else if ((w_pf_issue && w_resp_ok) || (r_pf_pend && w_pf_present)) begin
      r_pf_pend <= 1'b0;
    end
  end
`else
  assign w_pf_issue = 1'b0;
  assign w_pf_line  = '0;
`endif

  assign w_issue    = w_demand || w_pf_issue;
  assign w_req_line = w_demand ? w_fetch_line : w_pf_line;
  assign w_accept   = w_issue && w_resp_ok;

  // Fill frees only matched entries while allocation only picks free ones, so both can land together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line_valid <= '0;
      r_mshr_valid <= '0;
    end else begin
      if (w_fill_any)
        r_line_valid[w_fill_idx] <= 1'b1;
      r_mshr_valid <= (r_mshr_valid & ~w_fill_oh) | (w_accept ? w_alloc_oh : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill_any) begin
      r_line_tag[w_fill_idx]  <= w_fill_line[60:IDX_W];
      r_line_data[w_fill_idx] <= mem.Imem2proc_data;
    end
    for (int unsigned i = 0; i < MSHR_DEPTH; i++) begin
      if (w_accept && w_alloc_oh[i]) begin
        r_mshr_line[i] <= w_req_line;
        r_mshr_tag[i]  <= mem.Imem2proc_response;
      end
    end
  end

  assign mem.proc2Imem_command = (reset && w_issue) ? BUS_LOAD : BUS_NONE;
  assign mem.proc2Imem_addr    = (reset && w_issue) ? {w_req_line, 3'b000} : '0;

  assign Icache_data_out  = !reset   ? '0 :
                            w_bypass ? mem.Imem2proc_data : r_line_data[w_idx];
  assign Icache_valid_out = reset && (w_bypass || w_hit);
  assign mshr_full        = reset && w_full;
endmodule

// File: tb/tb_icache_nb.sv
// Self-checking bench for icache_nb: accepted bus loads are checked against a scoreboard queue.
module tb_icache_nb;
  localparam int unsigned TW = 4;
`ifdef ICACHE_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [63:0] fetch_addr;
  logic        br;
  logic [63:0] data_out;
  logic        valid_out;
  logic        full;

  int n_checks;
  int n_errors;
  int n_load;
  int n48;
  int n0;
  logic [63:0] sb_q[$];

  icache_nb_if #(.NUM_MEM_TAGS(16)) mem_if ();

  icache_nb #(
    .NUM_LINES   (32),
    .MSHR_DEPTH  (4),
    .NUM_MEM_TAGS(16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .proc2Icache_addr(fetch_addr),
    .branch_taken    (br),
    .mem             (mem_if),
    .Icache_data_out (data_out),
    .Icache_valid_out(valid_out),
    .mshr_full       (full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic b, input logic [TW-1:0] resp,
                       input logic [TW-1:0] mtag, input logic [63:0] mdata);
    fetch_addr                = a;
    br                        = b;
    mem_if.Imem2proc_response = resp;
    mem_if.Imem2proc_tag      = mtag;
    mem_if.Imem2proc_data     = mdata;
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_load(input logic [63:0] a);
    sb_q.push_back(a);
  endtask

  always @(negedge clock) begin
    if (reset && mem_if.proc2Imem_command == 2'd1) begin
      n_load++;
      if (mem_if.Imem2proc_response != '0) begin
        if (mem_if.proc2Imem_addr == 64'h48) n48++;
        if (sb_q.size() == 0) check("sb_unexpected_load", 64'(sb_q.size()), 64'd1);
        else                  check("sb_load_addr", mem_if.proc2Imem_addr, sb_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; n_load = 0; n48 = 0;
    reset = 1'b0;
    drive(64'h0, 1'b0, 4'd0, 4'd0, 64'h0);
    #3;
    check("rst_cmd",   64'(mem_if.proc2Imem_command), 64'd0);
    check("rst_addr",  mem_if.proc2Imem_addr, 64'h0);
    check("rst_data",  data_out, 64'h0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_full",  64'(full), 64'd0);
    next();
    reset = 1'b1;

    // single miss, bypass on fill, hit afterwards
    drive(64'h8, 1'b0, 4'd3, 4'd0, 64'h0); expect_load(64'h8);
    @(negedge clock);
    check("t2_cmd",   64'(mem_if.proc2Imem_command), 64'd1);
    check("t2_addr",  mem_if.proc2Imem_addr, 64'h8);
    check("t2_miss",  64'(valid_out), 64'd0);
    next();
    drive(64'h8, PF, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t2_nodup", 64'(mem_if.proc2Imem_command), 64'd0);
    next();
    drive(64'h8, 1'b0, 4'd0, 4'd3, 64'h1234);
    @(negedge clock);
    check("t2_byp_valid", 64'(valid_out), 64'd1);
    check("t2_byp_data",  data_out, 64'h1234);
    next();
    drive(64'h8, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t2_hit_valid", 64'(valid_out), 64'd1);
    check("t2_hit_data",  data_out, 64'h1234);
    check("t2_hit_cmd",   64'(mem_if.proc2Imem_command), 64'd0);
    next();

    // rejected responses cause re-drive, single allocation
    n0 = n_load;
    drive(64'h10, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t3_cmd",  64'(mem_if.proc2Imem_command), 64'd1);
    check("t3_addr", mem_if.proc2Imem_addr, 64'h10);
    next();
    drive(64'h10, 1'b0, 4'd0, 4'd0, 64'h0); next();
    drive(64'h10, 1'b0, 4'd5, 4'd0, 64'h0); expect_load(64'h10); next();
    drive(64'h10, PF, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t3_nodup", 64'(mem_if.proc2Imem_command), 64'd0);
    check("t3_full",  64'(full), 64'd0);
    next();
    drive(64'h10, 1'b0, 4'd0, 4'd5, 64'h55);
    @(negedge clock);
    check("t3_retries", 64'(n_load - n0), 64'd3);
    check("t3_byp",     data_out, 64'h55);
    next();

    // asynchronous reset with two entries outstanding
    drive(64'h100, 1'b0, 4'd1, 4'd0, 64'h0); expect_load(64'h100); next();
    drive(64'h108, 1'b0, 4'd2, 4'd0, 64'h0); expect_load(64'h108); next();
    drive(64'h200, 1'b0, 4'd0, 4'd0, 64'h0);
    #2 reset = 1'b0;
    #1;
    check("t1_cmd",   64'(mem_if.proc2Imem_command), 64'd0);
    check("t1_addr",  mem_if.proc2Imem_addr, 64'h0);
    check("t1_data",  data_out, 64'h0);
    check("t1_valid", 64'(valid_out), 64'd0);
    check("t1_full",  64'(full), 64'd0);
    next();
    reset = 1'b1;
    drive(64'h8, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t1_miss_valid", 64'(valid_out), 64'd0);
    check("t1_miss_cmd",   64'(mem_if.proc2Imem_command), 64'd1);
    next();
    drive(64'h100, 1'b0, 4'd0, 4'd1, 64'hdead);
    @(negedge clock);
    check("t1_stale_tag", 64'(valid_out), 64'd0);
    next();

    // fill the MSHR file
    drive(64'h8,  1'b0, 4'd1, 4'd0, 64'h0); expect_load(64'h8);  next();
    drive(64'h10, 1'b0, 4'd2, 4'd0, 64'h0); expect_load(64'h10); next();
    drive(64'h18, 1'b0, 4'd3, 4'd0, 64'h0); expect_load(64'h18); next();
    drive(64'h20, 1'b0, 4'd4, 4'd0, 64'h0); expect_load(64'h20); next();
    drive(64'h28, 1'b0, 4'd6, 4'd0, 64'h0);
    @(negedge clock);
    check("t4_full",    64'(full), 64'd1);
    check("t4_blocked", 64'(mem_if.proc2Imem_command), 64'd0);
    next();
    drive(64'h28, 1'b0, 4'd6, 4'd2, 64'h2222);
    @(negedge clock);
    check("t4_fill_cycle_cmd", 64'(mem_if.proc2Imem_command), 64'd0);
    next();
    drive(64'h28, 1'b0, 4'd7, 4'd0, 64'h0); expect_load(64'h28);
    @(negedge clock);
    check("t4_freed_cmd",  64'(mem_if.proc2Imem_command), 64'd1);
    check("t4_freed_addr", mem_if.proc2Imem_addr, 64'h28);
    check("t4_freed_full", 64'(full), 64'd0);
    next();
    drive(64'h28, PF, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t4_refull", 64'(full), 64'd1);
    next();

    // out-of-order completion and an unknown tag
    drive(64'h28, 1'b0, 4'd0, 4'd4, 64'h4444); next();
    drive(64'h28, 1'b0, 4'd0, 4'd1, 64'h1111); next();
    drive(64'h28, 1'b0, 4'd0, 4'd3, 64'h3333); next();
    begin
      logic [63:0] addrs [4] = '{64'h20, 64'h8, 64'h18, 64'h10};
      logic [63:0] datas [4] = '{64'h4444, 64'h1111, 64'h3333, 64'h2222};
      for (int i = 0; i < 4; i++) begin
        drive(addrs[i], 1'b0, 4'd0, 4'd0, 64'h0);
        @(negedge clock);
        check("t5_hit_valid", 64'(valid_out), 64'd1);
        check("t5_hit_data",  data_out, datas[i]);
        next();
      end
    end
    drive(64'h10, 1'b0, 4'd0, 4'd9, 64'hbad);
    @(negedge clock);
    check("t5_unk_data", data_out, 64'h2222);
    check("t5_unk_cmd",  64'(mem_if.proc2Imem_command), 64'd0);
    next();
    drive(64'h10, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t5_unk_after", data_out, 64'h2222);
    check("t5_unk_full",  64'(full), 64'd0);
    next();
    drive(64'h28, 1'b0, 4'd0, 4'd7, 64'h7777);
    @(negedge clock);
    check("t5_byp28", data_out, 64'h7777);
    next();

    // conflicting tag at index 1 replaces line 0x8
    drive(64'h108, 1'b0, 4'd2, 4'd0, 64'h0); expect_load(64'h108);
    @(negedge clock);
    check("rep_miss", 64'(valid_out), 64'd0);
    next();
    drive(64'h108, PF, 4'd0, 4'd2, 64'hab); next();
    drive(64'h108, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("rep_hit", data_out, 64'hab);
    next();
    drive(64'h8, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("rep_evict", 64'(valid_out), 64'd0);
    next();

    // next-line prefetch and redirect cancellation
    drive(64'h40, 1'b0, 4'd1, 4'd0, 64'h0); expect_load(64'h40); next();
    drive(64'h40, 1'b0, 4'd2, 4'd0, 64'h0);
    if (PF) expect_load(64'h48);
    @(negedge clock);
    check("t6_pf_cmd", 64'(mem_if.proc2Imem_command), 64'(PF));
    next();
    drive(64'h40, 1'b0, 4'd0, 4'd1, 64'h40); next();
    drive(64'h40, 1'b0, 4'd0, 4'd2, 64'h48); next();
    drive(64'h80, 1'b0, 4'd3, 4'd0, 64'h0); expect_load(64'h80); next();
    drive(64'h80, 1'b1, 4'd4, 4'd0, 64'h0);
    @(negedge clock);
    check("t6_br_drop", 64'(mem_if.proc2Imem_command), 64'd0);
    next();
    drive(64'h80, 1'b0, 4'd4, 4'd0, 64'h0);
    @(negedge clock);
    check("t6_br_cancel", 64'(mem_if.proc2Imem_command), 64'd0);
    next();
    drive(64'h80, 1'b0, 4'd0, 4'd3, 64'h80); next();
    drive(64'h0, 1'b0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    check("t6_loads_48", 64'(n48), 64'(PF));
    check("sb_drained",  64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/icache_nb.md
Name: icache_nb

Overview:
- Non-blocking, direct-mapped instruction cache with parametrised line count and miss-status-holding-register (MSHR) depth.
- Sits between the fetch stage and the tagged memory bus. Memory accepts a load by returning a nonzero tag and later returns data carrying that tag.
- Tracks several outstanding line misses at once. Fill data is forwarded to fetch in the cycle it returns.
- An optional next-line prefetcher is included.

Parameters:
- NUM_LINES, 32, number of 8-byte cache lines; power of 2, at least 2.
- MSHR_DEPTH, 4, maximum outstanding misses; 1 to 8.
- NUM_MEM_TAGS, 16, memory tag space; tag 0 is reserved and means "none".

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- proc2Icache_addr  in  64  fetch byte address; index = addr[3 +: IDX_W], tag = addr[63:3+IDX_W], where IDX_W = $clog2(NUM_LINES).
- branch_taken  in  1  redirect; suppresses this cycle's issue and cancels any pending prefetch.
- Imem2proc_response  in  TW  nonzero = request accepted, with this tag; TW = $clog2(NUM_MEM_TAGS).
- Imem2proc_data  in  64  returned line data.
- Imem2proc_tag  in  TW  nonzero = data valid for this tag.
- proc2Imem_command  out  2  BUS_NONE=0, BUS_LOAD=1.
- proc2Imem_addr  out  64  line-aligned request address (bits [2:0] are zero).
- Icache_data_out  out  64  instruction line for proc2Icache_addr.
- Icache_valid_out  out  1  Icache_data_out is valid this cycle.
- mshr_full  out  1  all MSHR entries in use.

Behaviour:
- State:
  - Per-line valid bit, tag and data.
  - Per-MSHR entry: valid, line_addr[63:3], mem_tag.
  - prefetch pending register pf_pend, with address pf_addr.
- Reset (asynchronous, reset==0):
  - All line valids, MSHR valids and pf_pend are cleared.
  - Outputs are forced to: command=BUS_NONE, addr=0, data_out=0, valid_out=0, mshr_full=0.
- Lookup (combinational, 0-cycle latency):
  - hit = line valid and tag equal.
  - Bypass: if Imem2proc_tag!=0 and matches a valid MSHR entry whose line_addr equals the fetch line, the output is Imem2proc_data with valid_out=1.
  - Otherwise the output is cache data, with valid_out=hit.
- Demand issue:
  - Condition: miss, no bypass, no valid MSHR entry for the same line_addr, !mshr_full, !branch_taken.
  - Action: command=BUS_LOAD, addr={fetch[63:3],3'b0}.
- Prefetch issue:
  - Takes the bus only when no demand issue is driven, pf_pend=1, !mshr_full, and pf_addr is neither cached nor in the MSHR.
  - If pf_addr is already present, pf_pend clears without issuing.
- Accept:
  - If command=BUS_LOAD and response!=0, the lowest-index free MSHR entry is allocated at posedge with {addr[63:3], response}.
  - If response==0, nothing is allocated; the same request is re-driven next cycle if its conditions still hold.
- Fill:
  - If Imem2proc_tag matches a valid entry, the line is written (valid=1, tag, data) and the entry freed at posedge.
  - Entries may complete in any order.
  - A nonzero tag that matches no entry is ignored.
- Simultaneous fill and accept in one cycle: both take effect. mshr_full is computed from registered state, so a freed entry is usable the next cycle.
- Fill to a line index whose tag differs: the old line is replaced.
- branch_taken:
  - Drops this cycle's issue.
  - Clears pf_pend.
  - Outstanding MSHR entries are kept and still fill, since the data is correct for their address.
- Capacity: never more than MSHR_DEPTH outstanding requests. When full, command=BUS_NONE.
- mshr_full = all MSHR valid bits are set.

Optional Feature:
- Macro ICACHE_PREFETCH_EN.
- Defined:
  - On any accepted demand miss, pf_pend<=1 and pf_addr<=line_addr+8 (64-bit wrap).
  - A new accepted demand miss overwrites a pending prefetch.
- Undefined: pf_pend is tied to 0, no prefetch logic is built, and only demand requests are issued.

Test Plan:
1. Reset low mid-operation with 2 MSHR entries busy -> outputs are BUS_NONE/0 immediately, the MSHR is empty, and a later fetch of 0x8 misses.
2. Fetch 0x8, response=3 -> one BUS_LOAD to 0x8. Tag 3 with data 0x1234 two cycles later -> valid_out=1 with data 0x1234 that cycle (bypass), and a hit on 0x8 the next cycle.
3. Fetch 0x10, response 0 for two cycles then 5 -> the request is re-driven three cycles and only one entry is allocated. Fetch 0x10 again while the entry is outstanding -> no duplicate request.
4. Four misses (0x8,0x10,0x18,0x20) accepted with tags 1-4 -> mshr_full=1 and a fifth miss issues nothing. Tag 2 returns -> a request is issued the following cycle.
5. Tags return out of order (4,1,3) -> lines 0x20, 0x8 and 0x18 all hit afterwards. Tag 9 (unknown) -> no state change.
6. ICACHE_PREFETCH_EN: miss 0x40 accepted -> next cycle a BUS_LOAD to 0x48. Same scenario with branch_taken=1 in the cycle after accept -> no request to 0x48. Macro undefined -> never a request to 0x48.
